// File: rtl/pc_fetch_unit.sv
// Instruction fetch front end: owns the PC, issues in-order memory reads and
// buffers returned words with their PCs in a small FIFO for the decode stage.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        br_taken,
  input  logic [31:0] opr_res,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic [31:0] pc_out,
  output logic [1:0]  fetch_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   pc;
  logic [31:0]   resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   fifo_pc   [DEPTH];

  logic [31:0]   target;
  logic [CW:0]   occupancy;
  logic          req_fire;
  logic          rsp_keep;
  logic          drop_dec;
  logic          pop;
  logic [CW-1:0] outst_after_rsp;
  logic [CW-1:0] drop_next;

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // the sender holds its payload stable until that edge.
  assign target    = opr_res & 32'hFFFF_FFFC;
  assign occupancy = {1'b0, fifo_count} + {1'b0, outstanding};

  assign imem_req_valid = (state != BOOT) && !br_taken && (occupancy < DEPTH_W);
  assign imem_addr      = pc;
  assign pc_out         = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = (fifo_count != '0);
  assign inst_out   = inst_valid ? fifo_inst[rd_ptr] : '0;
  assign inst_pc    = inst_valid ? fifo_pc[rd_ptr] : '0;
  assign pop        = inst_valid && inst_ready;

  // Responses belonging to squashed requests are swallowed via drop_cnt.
  assign drop_dec        = imem_rsp_valid && (drop_cnt != '0);
  assign drop_next       = drop_cnt - CW'(drop_dec);
  assign rsp_keep        = imem_rsp_valid && !br_taken && (drop_cnt == '0);
  assign outst_after_rsp = outstanding - CW'(imem_rsp_valid);

  assign fetch_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      outstanding <= outst_after_rsp + CW'(req_fire);
      if (br_taken) begin
        pc         <= target;
        resp_pc    <= target;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        drop_cnt   <= outst_after_rsp;
        state      <= (outst_after_rsp != '0) ? FLUSH : RUN;
      end else begin
        if (req_fire) begin
          pc <= pc + 32'd4;
        end
        if (rsp_keep) begin
          wr_ptr  <= wr_ptr + AW'(1);
          resp_pc <= resp_pc + 32'd4;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        fifo_count <= fifo_count + CW'(rsp_keep) - CW'(pop);
        drop_cnt   <= drop_next;
        case (state)
          BOOT:    state <= RUN;
          FLUSH:   state <= (drop_next == '0) ? RUN : FLUSH;
          default: state <= RUN;
        endcase
      end
    end
  end

  // Storage needs no reset: fifo_count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (rsp_keep) begin
      fifo_inst[wr_ptr] <= imem_rsp_data;
      fifo_pc[wr_ptr]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a latency-configurable in-order memory
// model, a decode-side pop recorder and per-scenario checking tasks.
module tb_pc_fetch_unit;

  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic        clk;
  logic        rst;
  logic        br_taken;
  logic [31:0] opr_res;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic [31:0] pc_out;
  logic [1:0]  fetch_state;

  logic        w_br_taken;
  logic [31:0] w_opr_res;
  logic        w_req_valid;
  logic        w_req_ready;
  logic [31:0] w_addr;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_data;
  logic        w_inst_valid;
  logic        w_inst_ready;
  logic [31:0] w_inst_out;
  logic [31:0] w_inst_pc;
  logic [31:0] w_pc_out;
  logic [1:0]  w_fetch_state;

  int          checks;
  int          failures;
  int          edge_cnt;
  int          mem_lat;
  logic        mem_hold;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] addr_log[$];
  logic [31:0] pop_pc_log[$];
  logic [31:0] pop_data_log[$];
  logic [31:0] w_addr_log[$];
  logic [31:0] w_pop_pc_log[$];
  logic [31:0] w_pop_data_log[$];
  logic [31:0] exp_q[$];
  logic        w_pend_v;
  logic [31:0] w_pend_a;

  pc_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .br_taken(br_taken), .opr_res(opr_res),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc),
    .pc_out(pc_out), .fetch_state(fetch_state)
  );

  pc_fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst), .br_taken(w_br_taken), .opr_res(w_opr_res),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready),
    .imem_addr(w_addr), .imem_rsp_valid(w_rsp_valid),
    .imem_rsp_data(w_rsp_data), .inst_valid(w_inst_valid),
    .inst_ready(w_inst_ready), .inst_out(w_inst_out), .inst_pc(w_inst_pc),
    .pc_out(w_pc_out), .fetch_state(w_fetch_state)
  );

  function automatic logic [31:0] inst_word(input logic [31:0] a);
    return a ^ 32'hCAFE_F00D;
  endfunction

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    edge_cnt = 0;
    forever begin
      @(posedge clk);
      edge_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // Main memory model: in-order, mem_lat edges from acceptance to response.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (!mem_hold && pend_addr.size() > 0 && pend_due[0] <= edge_cnt + 1) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = inst_word(pend_addr.pop_front());
          void'(pend_due.pop_front());
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_addr);
          pend_due.push_back(edge_cnt + 1 + mem_lat);
          addr_log.push_back(imem_addr);
        end
        if (inst_valid && inst_ready) begin
          pop_pc_log.push_back(inst_pc);
          pop_data_log.push_back(inst_out);
        end
      end
    end
  end

  // Wrap-instance memory: fixed one-cycle latency.
  initial begin
    w_rsp_valid = 1'b0;
    w_rsp_data  = '0;
    w_pend_v    = 1'b0;
    w_pend_a    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        w_rsp_valid = 1'b0;
        w_rsp_data  = '0;
        w_pend_v    = 1'b0;
      end else begin
        w_rsp_valid = w_pend_v;
        w_rsp_data  = inst_word(w_pend_a);
        w_pend_v    = w_req_valid && w_req_ready;
        w_pend_a    = w_addr;
        if (w_req_valid && w_req_ready) w_addr_log.push_back(w_addr);
        if (w_inst_valid && w_inst_ready) begin
          w_pop_pc_log.push_back(w_inst_pc);
          w_pop_data_log.push_back(w_inst_out);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    br_taken       = 1'b0;
    opr_res        = '0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b0;
    mem_hold       = 1'b0;
    mem_lat        = 1;
    steps(2);
    addr_log.delete();
    pop_pc_log.delete();
    pop_data_log.delete();
    w_addr_log.delete();
    w_pop_pc_log.delete();
    w_pop_data_log.delete();
    exp_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out actual=%h expected=%h", pc_out, 32'h0); end
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid actual=%b expected=0", imem_req_valid); end
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid actual=%b expected=0", inst_valid); end
    checks++; if ({inst_out, inst_pc} !== 64'h0) begin failures++; $display("FAIL reset_inst_out_pc actual=%h/%h expected=0/0", inst_out, inst_pc); end
    checks++; if (fetch_state !== 2'd0) begin failures++; $display("FAIL reset_state actual=%0d expected=0", fetch_state); end
    checks++; if (w_pc_out !== WRAP_PC) begin failures++; $display("FAIL reset_wrap_pc actual=%h expected=%h", w_pc_out, WRAP_PC); end
    checks++; if (w_fetch_state !== 2'd0) begin failures++; $display("FAIL reset_wrap_state actual=%0d expected=0", w_fetch_state); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step();
    checks++; if ({inst_valid, imem_req_valid, imem_addr} !== {1'b0, 1'b1, 32'h0}) begin failures++; $display("FAIL stream_boot_exit actual=%b/%b/%h expected=0/1/0", inst_valid, imem_req_valid, imem_addr); end
    step();
    checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL stream_lat2 actual=%b expected=0", inst_valid); end
    step();
    checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, inst_word(32'h0)}) begin failures++; $display("FAIL stream_first_inst actual=%b/%h/%h expected=1/0/%h", inst_valid, inst_pc, inst_out, inst_word(32'h0)); end
    steps(16);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    checks++; if (addr_log.size() < 8 || pop_pc_log.size() < 6) begin failures++; $display("FAIL stream_count actual=%0d/%0d required>=8/6", addr_log.size(), pop_pc_log.size()); end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      checks++; if (addr_log[i] !== exp_q[i]) begin failures++; $display("FAIL stream_addr[%0d] actual=%h expected=%h", i, addr_log[i], exp_q[i]); end
    end
    for (int i = 0; i < 6 && i < pop_pc_log.size(); i++) begin
      checks++; if ({pop_pc_log[i], pop_data_log[i]} !== {exp_q[i], inst_word(exp_q[i])}) begin failures++; $display("FAIL stream_pop[%0d] actual=%h/%h expected=%h/%h", i, pop_pc_log[i], pop_data_log[i], exp_q[i], inst_word(exp_q[i])); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    imem_req_ready = 1'b1;
    steps(10);
    checks++; if (addr_log.size() != 2) begin failures++; $display("FAIL bp_req_count actual=%0d expected=2", addr_log.size()); end
    if (addr_log.size() >= 2) begin
      checks++; if ({addr_log[0], addr_log[1]} !== {32'h0, 32'h4}) begin failures++; $display("FAIL bp_addrs actual=%h,%h expected=0,4", addr_log[0], addr_log[1]); end
    end
    checks++; if ({imem_req_valid, pc_out} !== {1'b0, 32'h8}) begin failures++; $display("FAIL bp_stalled actual=%b/%h expected=0/8", imem_req_valid, pc_out); end
    checks++; if ({inst_valid, inst_pc, inst_out} !== {1'b1, 32'h0, inst_word(32'h0)}) begin failures++; $display("FAIL bp_head_hold actual=%b/%h/%h expected=1/0/%h", inst_valid, inst_pc, inst_out, inst_word(32'h0)); end
    inst_ready = 1'b1;
    step();
    checks++; if (inst_pc !== 32'h4) begin failures++; $display("FAIL bp_second_head actual=%h expected=4", inst_pc); end
    steps(8);
    checks++; if (pop_pc_log.size() < 3 || addr_log.size() < 3) begin failures++; $display("FAIL bp_resume_count actual=%0d/%0d required>=3/3", pop_pc_log.size(), addr_log.size()); end
    else begin
      checks++; if ({pop_pc_log[0], pop_pc_log[1], pop_pc_log[2]} !== {32'h0, 32'h4, 32'h8}) begin failures++; $display("FAIL bp_pop_order actual=%h,%h,%h expected=0,4,8", pop_pc_log[0], pop_pc_log[1], pop_pc_log[2]); end
      checks++; if (addr_log[2] !== 32'h8) begin failures++; $display("FAIL bp_resume_addr actual=%h expected=8", addr_log[2]); end
    end
  endtask

  task automatic test_req_stall();
    do_reset();
    inst_ready = 1'b1;
    step();
    for (int i = 0; i < 6; i++) begin
      checks++; if ({imem_req_valid, imem_addr, pc_out} !== {1'b1, 32'h0, 32'h0}) begin failures++; $display("FAIL stall_hold[%0d] actual=%b/%h/%h expected=1/0/0", i, imem_req_valid, imem_addr, pc_out); end
      if (i < 5) step();
    end
    imem_req_ready = 1'b1;
    step();
    checks++; if (pc_out !== 32'h4 || addr_log.size() != 1) begin failures++; $display("FAIL stall_accept actual=%h/%0d expected=4/1", pc_out, addr_log.size()); end
  endtask

  task automatic test_redirect();
    do_reset();
    mem_hold = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    br_taken = 1'b1; opr_res = 32'h0000_0012;
    step();
    br_taken = 1'b0;
    checks++; if ({pc_out, fetch_state} !== {32'h10, 2'd1}) begin failures++; $display("FAIL redir_boot actual=%h/%0d expected=10/1", pc_out, fetch_state); end
    steps(3);
    checks++; if (addr_log.size() != 2 || pc_out !== 32'h18 || imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_inflight actual=%0d/%h/%b expected=2/18/0", addr_log.size(), pc_out, imem_req_valid); end
    br_taken = 1'b1; opr_res = 32'h0000_0103;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL redir_no_req actual=%b expected=0", imem_req_valid); end
    step();
    br_taken = 1'b0; mem_hold = 1'b0;
    checks++; if ({pc_out, fetch_state, inst_valid} !== {32'h100, 2'd2, 1'b0}) begin failures++; $display("FAIL redir_target actual=%h/%0d/%b expected=100/2/0", pc_out, fetch_state, inst_valid); end
    steps(10);
    checks++; if (fetch_state !== 2'd1) begin failures++; $display("FAIL redir_back_run actual=%0d expected=1", fetch_state); end
    checks++; if (pop_pc_log.size() < 2) begin failures++; $display("FAIL redir_pop_count actual=%0d required>=2", pop_pc_log.size()); end
    for (int i = 0; i < pop_pc_log.size(); i++) begin
      checks++; if ({pop_pc_log[i], pop_data_log[i]} !== {32'h100 + 32'(4 * i), inst_word(32'h100 + 32'(4 * i))}) begin failures++; $display("FAIL redir_pop[%0d] actual=%h/%h expected=%h", i, pop_pc_log[i], pop_data_log[i], 32'h100 + 32'(4 * i)); end
    end
  endtask

  task automatic test_coincident();
    do_reset();
    imem_req_ready = 1'b1;
    steps(3);
    checks++; if ({inst_valid, inst_pc} !== {1'b1, 32'h0}) begin failures++; $display("FAIL coin_setup actual=%b/%h expected=1/0", inst_valid, inst_pc); end
    br_taken = 1'b1; opr_res = 32'h0000_0200; inst_ready = 1'b1;
    step();
    br_taken = 1'b0;
    checks++; if ({inst_valid, pc_out, fetch_state} !== {1'b0, 32'h200, 2'd1}) begin failures++; $display("FAIL coin_after actual=%b/%h/%0d expected=0/200/1", inst_valid, pc_out, fetch_state); end
    checks++; if (addr_log.size() != 2 || pop_pc_log.size() != 1) begin failures++; $display("FAIL coin_counts actual=%0d/%0d expected=2/1", addr_log.size(), pop_pc_log.size()); end
    steps(6);
    checks++; if (pop_pc_log.size() < 2) begin failures++; $display("FAIL coin_resume_count actual=%0d required>=2", pop_pc_log.size()); end
    else begin
      checks++; if ({pop_pc_log[0], pop_pc_log[1], pop_data_log[1]} !== {32'h0, 32'h200, inst_word(32'h200)}) begin failures++; $display("FAIL coin_pops actual=%h,%h/%h expected=0,200/%h", pop_pc_log[0], pop_pc_log[1], pop_data_log[1], inst_word(32'h200)); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    mem_hold = 1'b1; imem_req_ready = 1'b1; inst_ready = 1'b1;
    steps(4);
    br_taken = 1'b1; opr_res = 32'h0000_0300;
    step();
    checks++; if ({pc_out, fetch_state} !== {32'h300, 2'd2}) begin failures++; $display("FAIL b2b_first actual=%h/%0d expected=300/2", pc_out, fetch_state); end
    opr_res = 32'h0000_0405;
    step();
    br_taken = 1'b0; mem_hold = 1'b0;
    checks++; if ({pc_out, fetch_state} !== {32'h404, 2'd2}) begin failures++; $display("FAIL b2b_second actual=%h/%0d expected=404/2", pc_out, fetch_state); end
    steps(10);
    checks++; if (pop_pc_log.size() < 1 || addr_log.size() < 3) begin failures++; $display("FAIL b2b_count actual=%0d/%0d required>=1/3", pop_pc_log.size(), addr_log.size()); end
    else begin
      checks++; if ({pop_pc_log[0], pop_data_log[0], addr_log[2]} !== {32'h404, inst_word(32'h404), 32'h404}) begin failures++; $display("FAIL b2b_target actual=%h/%h/%h expected=404/%h/404", pop_pc_log[0], pop_data_log[0], addr_log[2], inst_word(32'h404)); end
    end
  endtask

  task automatic test_wrap_and_midreset();
    do_reset();
    imem_req_ready = 1'b1;
    steps(12);
    exp_q.delete();
    exp_q.push_back(32'hFFFF_FFF8);
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    checks++; if (w_addr_log.size() < 3 || w_pop_pc_log.size() < 3) begin failures++; $display("FAIL wrap_count actual=%0d/%0d required>=3/3", w_addr_log.size(), w_pop_pc_log.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if ({w_addr_log[i], w_pop_pc_log[i], w_pop_data_log[i]} !== {exp_q[i], exp_q[i], inst_word(exp_q[i])}) begin failures++; $display("FAIL wrap_seq[%0d] actual=%h/%h/%h expected=%h", i, w_addr_log[i], w_pop_pc_log[i], w_pop_data_log[i], exp_q[i]); end
      end
    end
    checks++; if ({inst_valid, pc_out} !== {1'b1, 32'h8}) begin failures++; $display("FAIL midrst_pre actual=%b/%h expected=1/8", inst_valid, pc_out); end
    rst = 1'b1;
    step();
    checks++; if ({pc_out, imem_req_valid, inst_valid, inst_out, inst_pc, fetch_state} !== {32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 2'd0}) begin failures++; $display("FAIL midrst_main actual=%h/%b/%b/%h/%h/%0d expected=0/0/0/0/0/0", pc_out, imem_req_valid, inst_valid, inst_out, inst_pc, fetch_state); end
    checks++; if ({w_pc_out, w_req_valid, w_inst_valid, w_inst_out, w_inst_pc} !== {WRAP_PC, 1'b0, 1'b0, 32'h0, 32'h0}) begin failures++; $display("FAIL midrst_wrap actual=%h/%b/%b/%h/%h expected=%h/0/0/0/0", w_pc_out, w_req_valid, w_inst_valid, w_inst_out, w_inst_pc, WRAP_PC); end
    rst = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; br_taken = 1'b0; opr_res = '0;
    imem_req_ready = 1'b0; inst_ready = 1'b0; mem_hold = 1'b0; mem_lat = 1;
    w_br_taken = 1'b0; w_opr_res = '0; w_req_ready = 1'b1; w_inst_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_req_stall();
    test_redirect();
    test_coincident();
    test_back_to_back();
    test_wrap_and_midreset();
    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Owns the program counter and consumes the next-PC decision: redirect on `br_taken` to `opr_res`, otherwise sequential PC+4.
- Issues instruction-memory read requests over a valid/ready request channel and accepts in-order responses.
- Buffers fetched instructions with their PCs in a small FIFO, and presents them to decode over a valid/ready handshake.
- Sits between the branch-resolution logic and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, instruction FIFO entries; also the maximum number of outstanding memory requests (power of 2, ≥2).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- br_taken  input  1  redirect request, sampled each cycle.
- opr_res  input  32  redirect target; bits [1:0] are ignored (forced to 0).
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_addr  output  32  fetch address; equals pc_out.
- imem_rsp_valid  input  1  response valid; responses are in order, one per accepted request, with no backpressure.
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  FIFO head valid.
- inst_ready  input  1  decode accepts the head.
- inst_out  output  32  head instruction.
- inst_pc  output  32  PC of the head instruction.
- pc_out  output  32  current fetch PC.

Behaviour:
- Reset (rst=1 at an edge):
  - pc_out=RESET_PC, resp_pc=RESET_PC.
  - FIFO empty, outstanding=0, drop_cnt=0.
  - imem_req_valid=0, inst_valid=0, inst_out=0, inst_pc=0.
  - State=BOOT.
  - Reset overrides every other input, including mid-transaction; responses for pre-reset requests arriving after reset are ignored only if drop_cnt covers them, so memory must also be reset together with the unit.
- States:
  - BOOT lasts one cycle with no request, then goes to RUN.
  - RUN is normal fetch.
  - FLUSH is entered on redirect when the post-redirect outstanding count is >0. Requests may still issue in FLUSH. The unit returns to RUN when drop_cnt reaches 0.
- Issue rule:
  - imem_req_valid=1 iff state≠BOOT, br_taken=0, and fifo_count+outstanding < DEPTH.
  - imem_req_valid is a combinational function of registered state plus br_taken.
  - Once asserted without br_taken, imem_req_valid and imem_addr stay stable until accepted.
  - On acceptance, pc_out←pc_out+4 (mod 2^32, wrap 0xFFFF_FFFC→0) and outstanding increments.
- Response handling:
  - Every imem_rsp_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {imem_rsp_data, resp_pc} is written to the FIFO and resp_pc←resp_pc+4.
  - The capacity rule guarantees that a kept response never finds the FIFO full.
- Decode handshake:
  - A pop occurs on inst_valid && inst_ready.
  - inst_out and inst_pc hold stable while inst_valid=1 and the head is not popped.
  - Latency: a response written at edge N is visible on inst_valid after edge N (1 cycle; no bypass).
  - Simultaneous push and pop are allowed.
- Redirect (br_taken=1 at edge):
  - pc_out←{opr_res[31:2],2'b00}, resp_pc←the same value.
  - The FIFO is cleared. A head popped in the same cycle counts as delivered; the rest are flushed.
  - drop_cnt←outstanding after this cycle's response decrement. A response arriving in the redirect cycle is itself dropped.
  - No request issues in the redirect cycle.
- Back-to-back redirects: each redirect recomputes drop_cnt; the latest target wins.
- Counters: outstanding and drop_cnt are clog2(DEPTH)+1 bits wide, with drop_cnt ≤ outstanding at all times.

Test Plan:
- Reset then idle memory (imem_req_ready=1, 1-cycle response latency), inst_ready=1 → imem_addr sequence 0x0, 0x4, 0x8…; inst_pc matches each word; first inst_valid 3 cycles after reset release.
- inst_ready=0 with DEPTH=2 → exactly 2 requests (0x0, 0x4) issue, then imem_req_valid=0. Raise inst_ready → pops 0x0 then 0x4, fetch resumes at 0x8.
- Hold imem_req_ready=0 for 5 cycles → imem_req_valid=1 and imem_addr=0x0 stable throughout; no pc_out advance.
- Issue 0x10 and 0x14 outstanding, then br_taken=1, opr_res=0x0000_0103 → pc_out=0x100. The 2 in-flight responses are discarded (never reach inst_valid); the next delivered inst_pc=0x100.
- br_taken coincident with imem_rsp_valid and inst_valid&&inst_ready → head delivered once, response dropped, no request that cycle, FIFO empty after edge.
- RESET_PC=0xFFFF_FFF8 → addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; assert rst mid-fetch → all outputs return to reset values at the next edge.
